// File: rtl/chk_run_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chk_run_ctrl_if                                                          |
// | Control/report bundle between the WB registers, checker and run sequencer|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
// master = WB control registers plus the checker datapath.
// slave  = chk_run_ctrl.
// The optional first-error fields exist only when CHK_FIRST_ERR_EN is defined.
interface chk_run_ctrl_if #(
  parameter int RUN_LEN_W = 16,
  parameter int ERR_CNT_W = 16
);
  logic                 start_i;
  logic                 stop_i;
  logic [RUN_LEN_W-1:0] run_len_i;
  logic                 err_i;
  logic                 chk_clr_o;
  logic                 chk_en_o;
  logic                 busy_o;
  logic                 rpt_valid_o;
  logic                 rpt_ack_i;
  logic [ERR_CNT_W-1:0] rpt_err_cnt_o;
  logic [RUN_LEN_W-1:0] rpt_cycles_o;
  logic                 rpt_aborted_o;
`ifdef CHK_FIRST_ERR_EN
  logic                 rpt_first_vld_o;
  logic [RUN_LEN_W-1:0] rpt_first_err_o;
`endif

  modport master (
    output start_i, stop_i, run_len_i, err_i, rpt_ack_i,
    input  chk_clr_o, chk_en_o, busy_o, rpt_valid_o,
           rpt_err_cnt_o, rpt_cycles_o, rpt_aborted_o
`ifdef CHK_FIRST_ERR_EN
    , input rpt_first_vld_o, rpt_first_err_o
`endif
  );

  modport slave (
    input  start_i, stop_i, run_len_i, err_i, rpt_ack_i,
    output chk_clr_o, chk_en_o, busy_o, rpt_valid_o,
           rpt_err_cnt_o, rpt_cycles_o, rpt_aborted_o
`ifdef CHK_FIRST_ERR_EN
    , output rpt_first_vld_o, rpt_first_err_o
`endif
  );
endinterface
`default_nettype wire

// File: rtl/chk_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | chk_run_ctrl                                                             |
// | One checker run per start rising edge: clear, timed enable, error count, |
// | held report. Optional first-error capture via macro CHK_FIRST_ERR_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module chk_run_ctrl #(
  parameter int RUN_LEN_W  = 16,
  parameter int ERR_CNT_W  = 16,
  parameter int CLR_CYCLES = 4
) (
  input  wire logic     clk_i,
  input  wire logic     rst_i,
  chk_run_ctrl_if.slave bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_CLEAR  = 2'd1;
  localparam logic [1:0] ST_RUN    = 2'd2;
  localparam logic [1:0] ST_REPORT = 2'd3;

  localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

  localparam logic [CLR_W-1:0]     C_CLR_LAST = CLR_W'(CLR_CYCLES - 1);
  localparam logic [CLR_W-1:0]     C_CLR_ONE  = CLR_W'(1);
  localparam logic [RUN_LEN_W-1:0] C_RUN_ONE  = RUN_LEN_W'(1);
  localparam logic [ERR_CNT_W-1:0] C_ERR_ONE  = ERR_CNT_W'(1);
  localparam logic [ERR_CNT_W-1:0] C_ERR_MAX  = '1;

  logic [1:0]           state_q, state_d;
  logic [1:0]           start_hist_q;
  logic [RUN_LEN_W-1:0] run_len_q, run_len_d;
  logic [CLR_W-1:0]     clr_cnt_q, clr_cnt_d;
  logic [RUN_LEN_W-1:0] cyc_q, cyc_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 aborted_q, aborted_d;
  logic                 chk_clr_q;
  logic                 chk_en_q;
  logic                 busy_q;
  logic                 rpt_valid_q;
  logic                 start_rise;
`ifdef CHK_FIRST_ERR_EN
  logic                 first_vld_q, first_vld_d;
  logic [RUN_LEN_W-1:0] first_err_q, first_err_d;
`endif

  // A level already high out of reset reads as a rise because the history clears to 0.
  assign start_rise = (start_hist_q == 2'b01);

  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
    clr_cnt_d = clr_cnt_q;
    cyc_d     = cyc_q;
    err_cnt_d = err_cnt_q;
    aborted_d = aborted_q;
`ifdef CHK_FIRST_ERR_EN
    first_vld_d = first_vld_q;
    first_err_d = first_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start_rise) begin
          state_d   = ST_CLEAR;
          run_len_d = bus.run_len_i;
          clr_cnt_d = '0;
          cyc_d     = '0;
          err_cnt_d = '0;
          aborted_d = 1'b0;
`ifdef CHK_FIRST_ERR_EN
          first_vld_d = 1'b0;
          first_err_d = '0;
`endif
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + C_CLR_ONE;
        if (bus.stop_i) begin
          state_d   = ST_REPORT;
          aborted_d = 1'b1;
        end else if (clr_cnt_q == C_CLR_LAST) begin
          state_d = (run_len_q == '0) ? ST_REPORT : ST_RUN;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + C_RUN_ONE;
        if (bus.err_i && (err_cnt_q != C_ERR_MAX)) begin
          err_cnt_d = err_cnt_q + C_ERR_ONE;
        end
`ifdef CHK_FIRST_ERR_EN
        if (bus.err_i && !first_vld_q) begin
          first_vld_d = 1'b1;
          first_err_d = cyc_q;
        end
`endif
        // Completion is tested first so a stop on the final cycle is not an abort.
        if (cyc_d == run_len_q) begin
          state_d = ST_REPORT;
        end else if (bus.stop_i) begin
          state_d   = ST_REPORT;
          aborted_d = 1'b1;
        end
      end
      ST_REPORT: begin
        if (bus.rpt_ack_i) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      start_hist_q <= 2'b00;
      run_len_q    <= '0;
      clr_cnt_q    <= '0;
      cyc_q        <= '0;
      err_cnt_q    <= '0;
      aborted_q    <= 1'b0;
      chk_clr_q    <= 1'b0;
      chk_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      rpt_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_hist_q <= {start_hist_q[0], bus.start_i};
      run_len_q    <= run_len_d;
      clr_cnt_q    <= clr_cnt_d;
      cyc_q        <= cyc_d;
      err_cnt_q    <= err_cnt_d;
      aborted_q    <= aborted_d;
      chk_clr_q    <= (state_d == ST_CLEAR);
      chk_en_q     <= (state_d == ST_RUN);
      busy_q       <= (state_d != ST_IDLE);
      rpt_valid_q  <= (state_d == ST_REPORT);
    end
  end

`ifdef CHK_FIRST_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_vld_q <= 1'b0;
      first_err_q <= '0;
    end else begin
      first_vld_q <= first_vld_d;
      first_err_q <= first_err_d;
    end
  end

  assign bus.rpt_first_vld_o = first_vld_q;
  assign bus.rpt_first_err_o = first_err_q;
`endif

  assign bus.chk_clr_o     = chk_clr_q;
  assign bus.chk_en_o      = chk_en_q;
  assign bus.busy_o        = busy_q;
  assign bus.rpt_valid_o   = rpt_valid_q;
  assign bus.rpt_err_cnt_o = err_cnt_q;
  assign bus.rpt_cycles_o  = cyc_q;
  assign bus.rpt_aborted_o = aborted_q;

endmodule
`default_nettype wire

// File: tb/tb_chk_run_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_chk_run_ctrl                                                          |
// | Self-checking bench: vector table, corner sequences, randomized runs.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_chk_run_ctrl;

  localparam int RLW    = 16;
  localparam int ECW    = 16;
  localparam int ECW_S  = 4;
  localparam int CLR    = 4;
  localparam int GUARD  = 400;

  typedef struct {
    logic [15:0] run_len;
    int          stop_idx;    // RUN index carrying stop_i, -1 for none
    bit          stop_clr;    // stop_i during the first CLEAR cycle
    logic [63:0] err_mask;    // err_i per RUN index (indices >= 64 are 0)
    int          exp_err;
    int          exp_sat;     // count expected from the 4-bit counter instance
    int          exp_cyc;
    bit          exp_abort;
    int          exp_first;
    bit          exp_fvld;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  chk_run_ctrl_if #(.RUN_LEN_W(RLW), .ERR_CNT_W(ECW))   bus   ();
  chk_run_ctrl_if #(.RUN_LEN_W(RLW), .ERR_CNT_W(ECW_S)) bus_s ();

  assign bus_s.start_i   = bus.start_i;
  assign bus_s.stop_i    = bus.stop_i;
  assign bus_s.run_len_i = bus.run_len_i;
  assign bus_s.err_i     = bus.err_i;
  assign bus_s.rpt_ack_i = bus.rpt_ack_i;

  chk_run_ctrl #(.RUN_LEN_W(RLW), .ERR_CNT_W(ECW), .CLR_CYCLES(CLR)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  chk_run_ctrl #(.RUN_LEN_W(RLW), .ERR_CNT_W(ECW_S), .CLR_CYCLES(CLR)) dut_sat (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus_s)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: report derived from the run's rules, not from cycle timing.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int   len;
    r = v;
    len = int'(v.run_len);
    if (v.stop_clr) begin
      r.exp_cyc = 0; r.exp_abort = 1'b1;
    end else if (v.stop_idx >= 0 && v.stop_idx < len - 1) begin
      r.exp_cyc = v.stop_idx + 1; r.exp_abort = 1'b1;
    end else begin
      r.exp_cyc = len; r.exp_abort = 1'b0;
    end
    r.exp_err = 0; r.exp_fvld = 1'b0; r.exp_first = 0;
    for (int i = 0; i < r.exp_cyc && i < 64; i++) begin
      if (v.err_mask[i]) begin
        if (!r.exp_fvld) begin r.exp_fvld = 1'b1; r.exp_first = i; end
        r.exp_err++;
      end
    end
    r.exp_sat = (r.exp_err > 15) ? 15 : r.exp_err;
    return r;
  endfunction

  // Produce a clean 0->1 on start_i; returns at the negedge after the rise was sampled.
  task automatic launch(input logic [15:0] len);
    @(negedge clk);
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.err_i = 1'b0; bus.rpt_ack_i = 1'b0;
    bus.run_len_i = len;
    @(negedge clk);
    bus.start_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int g;
    g = 0;
    while (!bus.rpt_valid_o && g < GUARD) begin
      @(negedge clk); g++;
    end
    check({name, "_valid_timeout"}, bus.rpt_valid_o, 1);
  endtask

  task automatic run_and_check(input string tag, input vec_t v);
    int clr_n, en_n, g;
    bit done;
    launch(v.run_len);
    clr_n = 0; en_n = 0; g = 0; done = 1'b0;
    while (!done && g < GUARD) begin
      @(negedge clk); g++;
      bus.run_len_i = 16'($urandom);
      if (bus.rpt_valid_o) begin
        done = 1'b1;
      end else if (bus.chk_clr_o) begin
        clr_n++;
        bus.stop_i = v.stop_clr;
        bus.err_i  = 1'($urandom);
      end else if (bus.chk_en_o) begin
        bus.err_i  = (en_n < 64) ? v.err_mask[en_n] : 1'b0;
        bus.stop_i = (en_n == v.stop_idx);
        en_n++;
      end else begin
        bus.stop_i = 1'b0; bus.err_i = 1'b0;
      end
    end
    check({tag, "_timeout"}, done, 1);
    bus.stop_i = 1'($urandom);
    bus.err_i  = 1'($urandom);
    check({tag, "_clr_cycles"}, clr_n, v.stop_clr ? 1 : CLR);
    check({tag, "_en_cycles"}, en_n, v.exp_cyc);
    check({tag, "_err_cnt"}, bus.rpt_err_cnt_o, v.exp_err);
    check({tag, "_err_sat"}, bus_s.rpt_err_cnt_o, v.exp_sat);
    check({tag, "_cycles"}, bus.rpt_cycles_o, v.exp_cyc);
    check({tag, "_aborted"}, bus.rpt_aborted_o, v.exp_abort);
`ifdef CHK_FIRST_ERR_EN
    check({tag, "_first_vld"}, bus.rpt_first_vld_o, v.exp_fvld);
    if (v.exp_fvld) check({tag, "_first_err"}, bus.rpt_first_err_o, v.exp_first);
`endif
    @(negedge clk);
    bus.rpt_ack_i = 1'b1;
    @(negedge clk);
    bus.rpt_ack_i = 1'b0;
    bus.start_i   = 1'b0;
    check({tag, "_valid_after_ack"}, {bus.busy_o, bus.rpt_valid_o}, 0);
    check({tag, "_cycles_persist"}, bus.rpt_cycles_o, v.exp_cyc);
  endtask

  vec_t tbl[8];
  vec_t rv;
  logic [15:0] cap_err, cap_cyc;
  logic        cap_ab;
  bit          stable, rerun;
  int          en_seen, g;

  initial begin
    bus.start_i = 1'b0; bus.stop_i = 1'b0; bus.run_len_i = '0;
    bus.err_i = 1'b0; bus.rpt_ack_i = 1'b0;
    rst = 1'b1;

    //           len  stop clr mask                      err sat cyc ab first fvld
    tbl[0] = '{16'd10,  -1, 0, 64'h24,                     2,  2, 10, 0, 2, 1};
    tbl[1] = '{16'd100,  3, 0, 64'h8,                      1,  1,  4, 1, 3, 1};
    tbl[2] = '{16'd30,  -1, 0, 64'h3FFF_FFFF,             30, 15, 30, 0, 0, 1};
    tbl[3] = '{16'd0,   -1, 0, 64'hFFFF_FFFF_FFFF_FFFF,    0,  0,  0, 0, 0, 0};
    tbl[4] = '{16'd5,    4, 0, 64'h10,                     1,  1,  5, 0, 4, 1};
    tbl[5] = '{16'd1,   -1, 0, 64'h0,                      0,  0,  1, 0, 0, 0};
    tbl[6] = '{16'd7,   -1, 1, 64'hFFFF,                   0,  0,  0, 1, 0, 0};
    tbl[7] = '{16'd6,    0, 0, 64'h1,                      1,  1,  1, 1, 0, 1};

    @(negedge clk);
    check("rst_outputs", {bus.chk_clr_o, bus.chk_en_o, bus.busy_o, bus.rpt_valid_o, bus.rpt_aborted_o}, 0);
    check("rst_counters", {bus.rpt_err_cnt_o, bus.rpt_cycles_o}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_and_check($sformatf("vec%0d", i), tbl[i]);
    end

    // Start toggling during RUN and REPORT is dropped; record holds while ack is low.
    launch(16'd8);
    en_seen = 0; g = 0;
    while (!bus.rpt_valid_o && g < GUARD) begin
      @(negedge clk); g++;
      if (bus.chk_en_o) begin
        en_seen++;
        if (en_seen == 2) bus.start_i = 1'b0;
        if (en_seen == 4) bus.start_i = 1'b1;
      end
    end
    check("tog_valid", bus.rpt_valid_o, 1);
    check("tog_cycles", bus.rpt_cycles_o, 8);
    check("tog_err", bus.rpt_err_cnt_o, 0);
    cap_err = bus.rpt_err_cnt_o; cap_cyc = bus.rpt_cycles_o; cap_ab = bus.rpt_aborted_o;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.start_i = (i == 4) ? 1'b1 : 1'(i % 2);
      bus.stop_i = 1'b1; bus.err_i = 1'b1;
      @(negedge clk);
      if (!bus.rpt_valid_o || bus.rpt_err_cnt_o != cap_err ||
          bus.rpt_cycles_o != cap_cyc || bus.rpt_aborted_o != cap_ab) stable = 1'b0;
    end
    check("tog_record_stable", stable, 1);
    bus.stop_i = 1'b0; bus.err_i = 1'b0;
    bus.rpt_ack_i = 1'b1;
    @(negedge clk);
    bus.rpt_ack_i = 1'b0;
    check("tog_busy_after_ack", bus.busy_o, 0);
    rerun = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.busy_o) rerun = 1'b1;
    end
    check("tog_no_retrigger", rerun, 0);

    // Asynchronous reset mid-RUN with start held high restarts a run after release.
    launch(16'd20);
    g = 0;
    while (!bus.chk_en_o && g < GUARD) begin @(negedge clk); g++; end
    bus.err_i = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_ctrl_low", {bus.chk_clr_o, bus.chk_en_o, bus.busy_o, bus.rpt_valid_o, bus.rpt_aborted_o}, 0);
    check("arst_counts_low", {bus.rpt_err_cnt_o, bus.rpt_cycles_o}, 0);
    bus.err_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("arst_idle_one_edge", bus.busy_o, 0);
    @(negedge clk);
    check("arst_restart_clr", {bus.busy_o, bus.chk_clr_o}, 2'b11);
    wait_valid("arst");
    check("arst_cycles", bus.rpt_cycles_o, 20);
    check("arst_err", bus.rpt_err_cnt_o, 0);
    bus.rpt_ack_i = 1'b1;
    @(negedge clk);
    bus.rpt_ack_i = 1'b0;
    check("arst_done", bus.busy_o, 0);

    // Randomized runs against the reference model.
    for (int n = 0; n < 30; n++) begin
      rv.run_len  = 16'($urandom_range(0, 40));
      rv.stop_idx = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 45)) : -1;
      rv.stop_clr = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 2))
        0:       rv.err_mask = {$urandom, $urandom};
        1:       rv.err_mask = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        default: rv.err_mask = ~64'h0 ^ (64'h1 << $urandom_range(0, 63));
      endcase
      rv = model(rv);
      run_and_check($sformatf("rnd%0d", n), rv);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
